fp_gpio_ctrl: RTL and testbench
===============================

FP_GPIO_CTRL -- requirements
Module: fp_gpio_ctrl

Interface
REQ-001 Parameters: GPIO_REG_WIDTH, 12, pin count; SYNC_STAGES, 2, input synchroniser depth (legal 2..4); DB_W, 8, debounce counter width; OUT_MASK, 12'hD55, pins drivable from gpio_out; IN_MASK, 12'h022, pins reported on gpio_in/events; IO_DDR, 12'hD55, reset value of the direction register.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 fp_gpio_in  in  GPIO_REG_WIDTH  asynchronous front-panel pin inputs.
REQ-005 fp_gpio_out  out  GPIO_REG_WIDTH  registered pin output drive.
REQ-006 fp_gpio_ddr  out  GPIO_REG_WIDTH  pin direction, 1 = output.
REQ-007 gpio_out  in  GPIO_REG_WIDTH  requested output levels from core logic.
REQ-008 gpio_in  out  GPIO_REG_WIDTH  filtered, masked input levels.
REQ-009 ddr_wr_stb / ddr_wr_data  in  1 / GPIO_REG_WIDTH  single-cycle write of the direction register.
REQ-010 debounce_len  in  DB_W  debounce hold length, quasi-static.
REQ-011 irq_en  in  GPIO_REG_WIDTH  per-pin interrupt enable.
REQ-012 evt_clr  in  GPIO_REG_WIDTH  write-1-to-clear pulse vector for event flags.
REQ-013 evt_rise / evt_fall  out  GPIO_REG_WIDTH each  sticky edge flags.
REQ-014 irq  out  1  registered interrupt request.

Function
REQ-015 fp_gpio_in shall pass through a SYNC_STAGES-deep flop chain per pin; sync = last stage.
REQ-016 Per pin, a DB_W counter shall clear whenever sync == filt; while sync != filt it shall increment each cycle, and when it equals debounce_len with sync still != filt, filt shall load sync on that edge and the counter shall clear.
REQ-017 debounce_len = 0 shall give filt = sync delayed one cycle; any glitch shorter than debounce_len+1 cycles shall not change filt.
REQ-018 Counter shall saturate, never wrap; changing debounce_len mid-count shall compare against the new value on the next cycle.
REQ-019 gpio_in shall equal filt & IN_MASK, combinationally from the filt register.
REQ-020 filt_d shall register filt; evt_rise[i] shall set when filt & ~filt_d & IN_MASK, evt_fall[i] when ~filt & filt_d & IN_MASK, one cycle after filt changes.
REQ-021 Flags shall remain set until the matching evt_clr bit is pulsed; simultaneous set and clear on the same bit shall leave the flag set.
REQ-022 irq shall be registered as |((evt_rise | evt_fall) & irq_en), asserting one cycle after a flag sets.
REQ-023 ddr_reg shall load ddr_wr_data on ddr_wr_stb; fp_gpio_ddr = ddr_reg.
REQ-024 fp_gpio_out shall register gpio_out & OUT_MASK & ddr_reg, one-cycle latency.

Reset
REQ-025 Reset shall clear sync chain, filt, filt_d, counters, evt_rise, evt_fall, irq and fp_gpio_out to 0, and load ddr_reg with IO_DDR.
REQ-026 Reset shall take priority over ddr_wr_stb and event set; reset mid-debounce shall discard the count.
REQ-027 A pin held high through reset shall produce one evt_rise after release (filt restarts from 0).

Configuration
REQ-028 Macro FP_GPIO_DEBOUNCE_EN defined: debounce per REQ-016..018.
REQ-029 Macro FP_GPIO_DEBOUNCE_EN undefined: no counters; filt = sync wire (gpio_in latency SYNC_STAGES cycles); debounce_len ignored; all other behaviour unchanged.

Verification
REQ-030 Macro on, SYNC_STAGES=2, debounce_len=0, pin 1 0->1 -> gpio_in[1]=1 exactly 3 cycles after sampling edge; evt_rise[1]=1 one cycle later; irq=1 next cycle if irq_en[1]=1.
REQ-031 debounce_len=4, pin 5 high for 4 cycles then low -> gpio_in[5] stays 0, no events; high for 5 cycles -> gpio_in[5]=1, evt_rise[5]=1.
REQ-032 Pin 0 (not in IN_MASK) toggled -> gpio_in[0]=0, no flags, irq=0.
REQ-033 evt_clr[1] pulsed same cycle as new rise on pin 1 -> evt_rise[1] remains 1; later lone evt_clr[1] -> 0, irq drops next cycle.
REQ-034 gpio_out=12'hFFF, ddr_wr_data=12'h005 -> fp_gpio_out=12'h005 one cycle later; reset -> fp_gpio_ddr=12'hD55, fp_gpio_out=0.
REQ-035 Macro off, pin 5 1-cycle glitch -> gpio_in[5] pulses 1 cycle after 2-cycle delay, evt_rise[5] and evt_fall[5] both set.

Source files
------------

// File: rtl/fp_gpio_ctrl_if.sv
// Purpose : core-side register/event bundle of the front-panel GPIO controller.
// Latency : n/a (signal bundle only).
// Backpressure: none; strobes and pulse vectors are single-cycle and always accepted.
// Ports   : master = core logic (drives requests/config), slave = fp_gpio_ctrl.
interface fp_gpio_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int DB_W  = 8
);
    logic [WIDTH-1:0] gpio_out;      // requested output levels
    logic [WIDTH-1:0] gpio_in;       // filtered, masked input levels
    logic             ddr_wr_stb;    // single-cycle direction write strobe
    logic [WIDTH-1:0] ddr_wr_data;   // direction write data, 1 = output
    logic [DB_W-1:0]  debounce_len;  // debounce hold length, quasi-static
    logic [WIDTH-1:0] irq_en;        // per-pin interrupt enable
    logic [WIDTH-1:0] evt_clr;       // write-1-to-clear for event flags
    logic [WIDTH-1:0] evt_rise;      // sticky rising-edge flags
    logic [WIDTH-1:0] evt_fall;      // sticky falling-edge flags
    logic             irq;           // registered interrupt request

    modport master (
        output gpio_out, ddr_wr_stb, ddr_wr_data, debounce_len, irq_en, evt_clr,
        input  gpio_in, evt_rise, evt_fall, irq
    );

    modport slave (
        input  gpio_out, ddr_wr_stb, ddr_wr_data, debounce_len, irq_en, evt_clr,
        output gpio_in, evt_rise, evt_fall, irq
    );
endinterface

// File: rtl/fp_gpio_ctrl.sv
// Purpose : front-panel GPIO controller: input sync + optional debounce, sticky edge events, irq, direction reg, output drive.
// Latency : gpio_in SYNC_STAGES cycles (+1 with debounce), events +1, irq +1; fp_gpio_out 1 cycle.
// Backpressure: none; every input is sampled every cycle.
// Ports   : clk, reset (sync, active-high), fp_gpio_in (async pins), fp_gpio_out / fp_gpio_ddr (pin drive and
//           direction), core (fp_gpio_ctrl_if.slave: core-side levels, direction write, debounce, events, irq).
// Config  : define FP_GPIO_DEBOUNCE_EN to build the per-pin debounce counters; otherwise filt is the synchroniser output.
module fp_gpio_ctrl #(
    parameter int                        GPIO_REG_WIDTH = 12,
    parameter int                        SYNC_STAGES    = 2,       // legal 2..4
    parameter int                        DB_W           = 8,
    parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = 12'hD55,
    parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK        = 12'h022,
    parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR         = 12'hD55
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    fp_gpio_ctrl_if.slave             core
);

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 takes the raw pins, last stage is sync.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][GPIO_REG_WIDTH-1:0] sync_q;
    logic [GPIO_REG_WIDTH-1:0]                  sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= fp_gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Filtered level per pin.
    // ------------------------------------------------------------------
    logic [GPIO_REG_WIDTH-1:0] filt;

`ifdef FP_GPIO_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_ONE = 1;

    logic [GPIO_REG_WIDTH-1:0][DB_W-1:0] db_cnt;
    logic [GPIO_REG_WIDTH-1:0]           filt_q;

    // The counter only runs while sync disagrees with filt; a disagreement
    // that survives debounce_len+1 consecutive cycles is accepted. The
    // threshold test is >= so that lowering debounce_len below a running
    // count takes effect on the next cycle instead of stalling the pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= '0;
            filt_q <= '0;
        end else begin
            for (int i = 0; i < GPIO_REG_WIDTH; i++) begin
                if (sync[i] == filt_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= core.debounce_len) begin
                    filt_q[i] <= sync[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != {DB_W{1'b1}}) begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;   // saturate, never wrap
                end
            end
        end
    end

    assign filt = filt_q;
`else
    // No debounce: the synchroniser output is the filtered level.
    assign filt = sync;
`endif

    assign core.gpio_in = filt & IN_MASK;

    // ------------------------------------------------------------------
    // Edge detection and sticky event flags.
    // ------------------------------------------------------------------
    logic [GPIO_REG_WIDTH-1:0] filt_d;
    logic [GPIO_REG_WIDTH-1:0] rise_set;
    logic [GPIO_REG_WIDTH-1:0] fall_set;
    logic [GPIO_REG_WIDTH-1:0] evt_rise_q;
    logic [GPIO_REG_WIDTH-1:0] evt_fall_q;
    logic                      irq_q;

    assign rise_set =  filt & ~filt_d & IN_MASK;
    assign fall_set = ~filt &  filt_d & IN_MASK;

    // Set is OR-ed in after the clear so a new edge in the clear cycle is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d     <= '0;
            evt_rise_q <= '0;
            evt_fall_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            filt_d     <= filt;
            evt_rise_q <= (evt_rise_q & ~core.evt_clr) | rise_set;
            evt_fall_q <= (evt_fall_q & ~core.evt_clr) | fall_set;
            irq_q      <= |((evt_rise_q | evt_fall_q) & core.irq_en);
        end
    end

    assign core.evt_rise = evt_rise_q;
    assign core.evt_fall = evt_fall_q;
    assign core.irq      = irq_q;

    // ------------------------------------------------------------------
    // Direction register and output drive.
    // ------------------------------------------------------------------
    logic [GPIO_REG_WIDTH-1:0] ddr_reg;
    logic [GPIO_REG_WIDTH-1:0] out_q;

    // Output drive uses the direction value in force before any write this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_reg <= IO_DDR;
            out_q   <= '0;
        end else begin
            if (core.ddr_wr_stb) begin
                ddr_reg <= core.ddr_wr_data;
            end
            out_q <= core.gpio_out & OUT_MASK & ddr_reg;
        end
    end

    assign fp_gpio_ddr = ddr_reg;
    assign fp_gpio_out = out_q;

endmodule

// File: tb/tb_fp_gpio_ctrl.sv
// Purpose : self-checking bench for fp_gpio_ctrl (direction/output table plus input-path sequences).
// Latency : checks sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_fp_gpio_ctrl;

    localparam int W = 12;
`ifdef FP_GPIO_DEBOUNCE_EN
    localparam int GIN_LAT = 3;   // cycles from pin change to gpio_in, debounce_len = 0
`else
    localparam int GIN_LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] fp_gpio_in;
    logic [W-1:0] fp_gpio_out;
    logic [W-1:0] fp_gpio_ddr;

    fp_gpio_ctrl_if #(.WIDTH(W), .DB_W(8)) core_if ();

    fp_gpio_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .fp_gpio_in  (fp_gpio_in),
        .fp_gpio_out (fp_gpio_out),
        .fp_gpio_ddr (fp_gpio_ddr),
        .core        (core_if)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [W-1:0] gout;
        logic         stb;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_ddr;
    } vec_t;

    localparam int NV = 9;
    vec_t         vec [NV];
    logic [2*W-1:0] sb_q [$];
    logic [2*W-1:0] sb_item;
    logic         seen;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Expected values: out = gout & D55 & (ddr before this edge); ddr = wdata if stb.
        vec[0] = '{12'hFFF, 1'b0, 12'h000, 12'hD55, 12'hD55};
        vec[1] = '{12'hFFF, 1'b1, 12'h005, 12'hD55, 12'h005};
        vec[2] = '{12'hFFF, 1'b0, 12'h000, 12'h005, 12'h005};
        vec[3] = '{12'h0F0, 1'b1, 12'hFFF, 12'h000, 12'hFFF};
        vec[4] = '{12'h0F0, 1'b0, 12'h000, 12'h050, 12'hFFF};
        vec[5] = '{12'hAAA, 1'b1, 12'h2AA, 12'h800, 12'h2AA};
        vec[6] = '{12'hFFF, 1'b0, 12'h000, 12'h000, 12'h2AA};
        vec[7] = '{12'hFFF, 1'b1, 12'h1FF, 12'h000, 12'h1FF};
        vec[8] = '{12'hFFF, 1'b0, 12'h000, 12'h155, 12'h1FF};

        reset                = 1'b1;
        fp_gpio_in           = '0;
        core_if.gpio_out     = '0;
        core_if.ddr_wr_stb   = 1'b0;
        core_if.ddr_wr_data  = '0;
        core_if.debounce_len = '0;
        core_if.irq_en       = '0;
        core_if.evt_clr      = '0;
        tick(3);

        // Reset state
        check("rst_out",  fp_gpio_out, 12'h000);
        check("rst_ddr",  fp_gpio_ddr, 12'hD55);
        check("rst_gin",  core_if.gpio_in, 12'h000);
        check("rst_rise", core_if.evt_rise | core_if.evt_fall, 12'h000);
        check("rst_irq",  {11'b0, core_if.irq}, 12'h000);
        reset = 1'b0;

        // Direction / output table via scoreboard
        for (int i = 0; i < NV; i++) begin
            core_if.gpio_out    = vec[i].gout;
            core_if.ddr_wr_stb  = vec[i].stb;
            core_if.ddr_wr_data = vec[i].wdata;
            sb_q.push_back({vec[i].exp_out, vec[i].exp_ddr});
            tick(1);
            core_if.ddr_wr_stb = 1'b0;
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                sb_item = sb_q.pop_front();
                check($sformatf("vec%0d_out", i), fp_gpio_out, sb_item[2*W-1:W]);
                check($sformatf("vec%0d_ddr", i), fp_gpio_ddr, sb_item[W-1:0]);
            end
        end

        // Reset beats a concurrent direction write
        reset               = 1'b1;
        core_if.ddr_wr_stb  = 1'b1;
        core_if.ddr_wr_data = 12'h000;
        tick(1);
        core_if.ddr_wr_stb = 1'b0;
        check("rstpri_ddr", fp_gpio_ddr, 12'hD55);
        check("rstpri_out", fp_gpio_out, 12'h000);
        reset            = 1'b0;
        core_if.gpio_out = '0;

        // Unmasked pin 0 toggled: nothing reported
        core_if.irq_en = 12'hFFF;
        fp_gpio_in     = 12'h001;
        tick(6);
        check("pin0_gin", core_if.gpio_in, 12'h000);
        fp_gpio_in = 12'h000;
        tick(6);
        check("pin0_rise", core_if.evt_rise, 12'h000);
        check("pin0_fall", core_if.evt_fall, 12'h000);
        check("pin0_irq",  {11'b0, core_if.irq}, 12'h000);

        // Pin 1 rise: gpio_in, flag, irq latencies
        core_if.irq_en = 12'h002;
        fp_gpio_in     = 12'h002;
        tick(GIN_LAT - 1);
        check("p1_gin_early", core_if.gpio_in, 12'h000);
        tick(1);
        check("p1_gin", core_if.gpio_in, 12'h002);
        check("p1_rise_early", core_if.evt_rise, 12'h000);
        tick(1);
        check("p1_rise", core_if.evt_rise, 12'h002);
        check("p1_irq_early", {11'b0, core_if.irq}, 12'h000);
        tick(1);
        check("p1_irq", {11'b0, core_if.irq}, 12'h001);

        // Lone clear: flag drops, irq follows one cycle later
        core_if.evt_clr = 12'h002;
        tick(1);
        core_if.evt_clr = 12'h000;
        check("clr_rise", core_if.evt_rise, 12'h000);
        check("clr_irq_hold", {11'b0, core_if.irq}, 12'h001);
        tick(1);
        check("clr_irq", {11'b0, core_if.irq}, 12'h000);

        // Pin 1 fall, then clear it
        fp_gpio_in = 12'h000;
        tick(GIN_LAT + 1);
        check("p1_fall", core_if.evt_fall, 12'h002);
        tick(1);
        check("p1_fall_irq", {11'b0, core_if.irq}, 12'h001);
        core_if.evt_clr = 12'h002;
        tick(1);
        core_if.evt_clr = 12'h000;
        tick(1);
        check("p1_fall_clr", core_if.evt_fall, 12'h000);
        check("p1_fall_clr_irq", {11'b0, core_if.irq}, 12'h000);

        // Clear in the same cycle as a new rise: set wins
        fp_gpio_in = 12'h002;
        tick(GIN_LAT);
        core_if.evt_clr = 12'h002;
        tick(1);
        core_if.evt_clr = 12'h000;
        check("setwins_rise", core_if.evt_rise, 12'h002);
        core_if.evt_clr = 12'h002;
        tick(1);
        core_if.evt_clr = 12'h000;
        check("setwins_clr", core_if.evt_rise, 12'h000);
        tick(1);
        check("setwins_irq", {11'b0, core_if.irq}, 12'h000);

`ifdef FP_GPIO_DEBOUNCE_EN
        // debounce_len = 4: 4-cycle pulse rejected, 5-cycle pulse accepted
        core_if.debounce_len = 8'd4;
        fp_gpio_in = 12'h022;
        tick(4);
        fp_gpio_in = 12'h002;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            seen = seen | core_if.gpio_in[5];
        end
        check("db4_gin", {11'b0, seen}, 12'h000);
        check("db4_evt", (core_if.evt_rise | core_if.evt_fall) & 12'h020, 12'h000);
        fp_gpio_in = 12'h022;
        tick(5);
        fp_gpio_in = 12'h002;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            seen = seen | core_if.gpio_in[5];
        end
        check("db5_gin", {11'b0, seen}, 12'h001);
        check("db5_rise", core_if.evt_rise & 12'h020, 12'h020);
        check("db5_fall", core_if.evt_fall & 12'h020, 12'h020);
        core_if.debounce_len = 8'd0;
`else
        // No debounce: a 1-cycle glitch on pin 5 passes straight through
        fp_gpio_in = 12'h022;
        tick(1);
        fp_gpio_in = 12'h002;
        check("gl_gin0", core_if.gpio_in & 12'h020, 12'h000);
        tick(1);
        check("gl_gin1", core_if.gpio_in & 12'h020, 12'h020);
        tick(1);
        check("gl_gin2", core_if.gpio_in & 12'h020, 12'h000);
        check("gl_rise", core_if.evt_rise & 12'h020, 12'h020);
        tick(1);
        check("gl_fall", core_if.evt_fall & 12'h020, 12'h020);
`endif

        // Pin 1 held high through reset yields one fresh rise
        fp_gpio_in = 12'h002;
        reset      = 1'b1;
        tick(3);
        check("hr_gin", core_if.gpio_in, 12'h000);
        check("hr_evt", core_if.evt_rise | core_if.evt_fall, 12'h000);
        check("hr_irq", {11'b0, core_if.irq}, 12'h000);
        reset = 1'b0;
        tick(GIN_LAT);
        check("hr_gin_after", core_if.gpio_in, 12'h002);
        check("hr_rise_early", core_if.evt_rise, 12'h000);
        tick(1);
        check("hr_rise", core_if.evt_rise, 12'h002);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
